massive_pwm_axi_slave: RTL

//  AXI4-Lite responder for the massive_pwm IP: terminates the S00_AXI bus driven by the system

---
 rtl/massive_pwm_pkg.sv | 31 +++
 rtl/massive_pwm_channel.sv | 33 +++
 rtl/massive_pwm_axi_slave.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/massive_pwm_pkg.sv
// Shared constants for the massive_pwm AXI4-Lite slave: register map, CTRL fields,
// response codes and bus FSM encodings.
package massive_pwm_pkg;

  localparam int REG_WORDS = 4;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DUTY01 = 2'd1;
  localparam logic [1:0] ADDR_DUTY23 = 2'd2;
  localparam logic [1:0] ADDR_DUTY45 = 2'd3;

  localparam int CTRL_POL_BIT = 16;
  localparam int CTRL_EN_BIT  = 24;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/massive_pwm_channel.sv
// One PWM channel: duty shadow register, compare against the shared counter,
// polarity and the output flop.
module massive_pwm_channel
  import massive_pwm_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 en,
  input  logic                 pol_live,
  input  logic                 pol_sh,
  input  logic [CNT_WIDTH-1:0] cnt,
  input  logic [CNT_WIDTH-1:0] duty,
  output logic                 pwm
);

  logic [CNT_WIDTH-1:0] duty_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_sh <= '0;
      pwm     <= 1'b0;
    end else begin
      if (load) duty_sh <= duty;
      // Disabled channels idle at the live polarity so the pin follows software at once
      if (en) pwm <= (cnt < duty_sh) ^ pol_sh;
      else    pwm <= pol_live;
    end
  end

endmodule

// File: rtl/massive_pwm_axi_slave.sv
// AXI4-Lite slave with four R/W registers driving six PWM outputs from one
// shared period counter.
//
//   state  | meaning
//   W_IDLE | waiting for AW and W together
//   W_RESP | BVALID high, waiting for BREADY
//   R_IDLE | waiting for AR
//   R_DATA | RVALID high with RDATA held, waiting for RREADY
module massive_pwm_axi_slave
  import massive_pwm_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int CNT_WIDTH          = 16,
  parameter int NUM_CH             = 6
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_CH-1:0]               pwm_out
);

  logic                          clk;
  logic                          rst;
  logic [C_S_AXI_DATA_WIDTH-1:0] regs [REG_WORDS];
  wr_state_t                     wr_state;
  rd_state_t                     rd_state;
  logic                          wr_accept;
  logic                          rd_accept;
  logic [1:0]                    waddr;
  logic [1:0]                    raddr;
  logic                          unused_sig;

  assign clk   = S_AXI_ACLK;
  assign rst   = S_AXI_ARESET;
  assign waddr = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign raddr = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign unused_sig = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // READY is a combinational accept pulse so a write or read can complete every 2 cycles
  assign wr_accept = !rst && (wr_state == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID
                     && !S_AXI_BVALID;
  assign rd_accept = !rst && (rd_state == R_IDLE) && S_AXI_ARVALID && !S_AXI_RVALID;

  assign S_AXI_AWREADY = wr_accept;
  assign S_AXI_WREADY  = wr_accept;
  assign S_AXI_ARREADY = rd_accept;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_RRESP   = RESP_OKAY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state     <= W_IDLE;
      S_AXI_BVALID <= 1'b0;
      for (int i = 0; i < REG_WORDS; i++) regs[i] <= '0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (wr_accept) begin
            regs[waddr]  <= strb_merge(regs[waddr], S_AXI_WDATA, S_AXI_WSTRB);
            S_AXI_BVALID <= 1'b1;
            wr_state     <= W_RESP;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
            wr_state     <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Read samples regs before the same-edge write lands, so a colliding read sees the old value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state     <= R_IDLE;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (rd_accept) begin
            S_AXI_RDATA  <= regs[raddr];
            S_AXI_RVALID <= 1'b1;
            rd_state     <= R_DATA;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
            rd_state     <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  logic                 en;
  logic                 pol_live;
  logic                 pol_sh;
  logic [CNT_WIDTH-1:0] period;
  logic [CNT_WIDTH-1:0] period_sh;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 wrap;
  logic                 shadow_load;

  assign en          = regs[ADDR_CTRL][CTRL_EN_BIT];
  assign pol_live    = regs[ADDR_CTRL][CTRL_POL_BIT];
  assign period      = regs[ADDR_CTRL][CNT_WIDTH-1:0];
  assign wrap        = (cnt >= period_sh);
  assign shadow_load = !en || wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      period_sh <= '0;
      pol_sh    <= 1'b0;
    end else begin
      if (shadow_load) begin
        period_sh <= period;
        pol_sh    <= pol_live;
      end
      if (!en || wrap) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam int REG_IDX = 1 + g / 2;
    localparam int LSB     = (g % 2) * 16;
    logic [CNT_WIDTH-1:0] duty;
    assign duty = regs[REG_IDX][LSB +: CNT_WIDTH];

    massive_pwm_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .load     (shadow_load),
      .en       (en),
      .pol_live (pol_live),
      .pol_sh   (pol_sh),
      .cnt      (cnt),
      .duty     (duty),
      .pwm      (pwm_out[g])
    );
  end

endmodule
